sobel_window_gen: RTL
=====================

Name: sobel_window_gen

Overview:
Upstream neighbour of the Sobel stage. Takes a raster-order 8-bit grayscale pixel stream, one pixel per accepted cycle. Buffers the two previous image lines and presents a registered 3x3 neighbourhood on nine byte outputs with a valid strobe, matching the Sobel stage's window inputs directly. Only fully interior windows are emitted; there is no padding and no backpressure.

Parameters:
IMG_WIDTH, 640, pixels per line; must be >= 3
IMG_HEIGHT, 480, lines per frame; must be >= 3

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
pix_in  input  8  incoming pixel, raster order
pix_valid  input  1  pix_in is accepted this cycle
row0_0, row0_1, row0_2  output  8 each  top window row (oldest line), _0 left/oldest column, _2 right/newest column
row1_0, row1_1, row1_2  output  8 each  middle window row (previous line)
row2_0, row2_1, row2_2  output  8 each  bottom window row (current line); row2_2 = most recent accepted pixel
valid_out  output  1  window outputs valid this cycle (one-cycle pulse per window)
frame_done  output  1  one-cycle pulse coincident with valid_out of the last window of a frame

Behaviour:
- Reset, synchronous on clk when rst=1: col/row counters = 0; all nine window outputs = 0; valid_out = 0; frame_done = 0. Line-buffer contents are not cleared; stale data is never exposed because of the valid gating below.
- Storage: two line buffers, each IMG_WIDTH x 8: LB1 holds the previous line and LB0 holds the line before that. A 3x3 register window.
- On an accepted pixel (pix_valid=1) at position (r,c), all updates land on the same edge:
  - Each window row shifts left: x_0 <= x_1, x_1 <= x_2.
  - row0_2 <= LB0[c], row1_2 <= LB1[c], row2_2 <= pix_in.
  - LB0[c] <= old LB1[c], LB1[c] <= pix_in.
  - Reads use pre-write values.
- Latency: valid_out is asserted exactly 1 cycle after the accepting edge, only if r >= 2 and c >= 2 (the window's bottom-right pixel is (r,c)).
- Windows per frame: (IMG_HEIGHT-2)*(IMG_WIDTH-2).
- Counters:
  - c increments on each accept. At c = IMG_WIDTH-1 it wraps to 0 and r increments.
  - At r = IMG_HEIGHT-1 with c = IMG_WIDTH-1, both wrap to 0. The next accepted pixel is (0,0) of the next frame.
- No-accept cycles (pix_valid=0): counters, line buffers and window outputs hold. valid_out and frame_done = 0. Gaps of any length are allowed, including gaps at line or frame boundaries.
- Line start: columns 0 and 1 of each line shift in the previous line's tail. This is harmless because valid_out stays low for c < 2.
- Frame start: rows 0 and 1 never raise valid_out, even though the line buffers hold previous-frame data.
- frame_done = 1 only in the cycle valid_out is high for window (IMG_HEIGHT-1, IMG_WIDTH-1).
- Reset mid-frame: takes priority over pix_valid in the same cycle. The pixel is discarded and the next accepted pixel is (0,0).
- Throughput: one pixel per clock sustained. Max back-to-back valid_out run is IMG_WIDTH-2 cycles.

Optional Feature:
Macro SOBEL_WIN_SOF_EN.
- Defined: adds input port sof_in (1 bit, after pix_valid). If sof_in=1 with pix_valid=1, that pixel is treated as (0,0): counters are forced and the pixel is processed normally. This resynchronises after truncated frames. sof_in with pix_valid=0 is ignored.
- Undefined: no sof_in port; frame alignment comes from reset and the counters only.

Test Plan:
Common setup for all scenarios: IMG_WIDTH=5, IMG_HEIGHT=4, pixel value = 10*r+c, pix_valid continuous.
1. Reset then a full frame -> first valid_out one cycle after pixel 22 is accepted, with window 0,1,2 / 10,11,12 / 20,21,22. Exactly 6 valid_out pulses in the frame. All window outputs 0 before the first accept.
2. Same frame with 1–3 idle cycles inserted randomly between pixels -> identical 6 windows in the same order. valid_out never high in an idle-following cycle without an accept.
3. End of frame -> last window 22,23,24 / 32,33,34 with frame_done=1 in the same cycle only. Second frame sent back-to-back yields no valid_out for its rows 0–1; its first window is 0,1,2 / 10,11,12 / 20,21,22 again.
4. Assert rst for 1 cycle after 7 accepted pixels, also with pix_valid=1 in the reset cycle -> outputs zeroed next cycle. A fresh frame afterwards produces its first window after its 13th accepted pixel, with values as in scenario 1.
5. Column wrap check -> no valid_out after pixels 30 or 31 (c < 2). valid_out after pixel 32 with window 10,11,12 / 20,21,22 / 30,31,32.
6. (SOBEL_WIN_SOF_EN) Send 9 pixels of a frame, then sof_in=1 with a new frame -> counters restart. First window after the new frame's pixel 22, with values as in scenario 1.

Source files
------------

// File: rtl/sobel_window_gen.sv
// 3x3 sliding-window generator for a raster pixel stream, feeding the Sobel stage.
// Optional macro SOBEL_WIN_SOF_EN adds sof_in to force the current pixel to (0,0).
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
`ifdef SOBEL_WIN_SOF_EN
  input  logic       sof_in,
`endif
  output logic [7:0] row0_0,
  output logic [7:0] row0_1,
  output logic [7:0] row0_2,
  output logic [7:0] row1_0,
  output logic [7:0] row1_1,
  output logic [7:0] row1_2,
  output logic [7:0] row2_0,
  output logic [7:0] row2_1,
  output logic [7:0] row2_2,
  output logic       valid_out,
  output logic       frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic [7:0]    win_q [3][3];
  logic [7:0]    win_d [3][3];
  logic          valid_q, valid_d;
  logic          frame_done_q, frame_done_d;
  logic          sof;
  logic          last_col, last_row;

  logic [7:0] lb0_mem [0:IMG_WIDTH-1];
  logic [7:0] lb1_mem [0:IMG_WIDTH-1];

`ifdef SOBEL_WIN_SOF_EN
  assign sof = sof_in;
`else
  assign sof = 1'b0;
`endif

  always_comb begin
    cur_col      = sof ? '0 : col_q;
    cur_row      = sof ? '0 : row_q;
    last_col     = (cur_col == CW'(IMG_WIDTH - 1));
    last_row     = (cur_row == RW'(IMG_HEIGHT - 1));
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    valid_d      = 1'b0;
    frame_done_d = 1'b0;
    if (pix_valid) begin
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      // Line buffers are read before this edge's write lands.
      win_d[0][2]  = lb0_mem[cur_col];
      win_d[1][2]  = lb1_mem[cur_col];
      win_d[2][2]  = pix_in;
      valid_d      = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      frame_done_d = valid_d && last_col && last_row;
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_q[i][j] <= 8'd0;
        end
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  // Line buffers are never cleared; valid gating hides stale contents.
  always_ff @(posedge clk) begin
    if (!rst && pix_valid) begin
      lb0_mem[cur_col] <= lb1_mem[cur_col];
      lb1_mem[cur_col] <= pix_in;
    end
  end

  assign row0_0     = win_q[0][0];
  assign row0_1     = win_q[0][1];
  assign row0_2     = win_q[0][2];
  assign row1_0     = win_q[1][0];
  assign row1_1     = win_q[1][1];
  assign row1_2     = win_q[1][2];
  assign row2_0     = win_q[2][0];
  assign row2_1     = win_q[2][1];
  assign row2_2     = win_q[2][2];
  assign valid_out  = valid_q;
  assign frame_done = frame_done_q;

endmodule
